mem_test_master: RTL and testbench

- Parametrised successor to the memory checker's traffic engine: an Avalon-MM master that generates write, read and write-then-read test traffic.
- Supports sequential or LFSR-random addressing and bursts of 1..2**BURST_W-1 words.
- Compares read data against a regenerated LFSR data pattern.
- Sits between the CSR block (config/start/status) and the memory under test. One outstanding read at a time.

---
 rtl/mem_test_master.sv | 195 +++++++++++++++++++
 tb/tb_mem_test_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_master.sv
// Avalon-MM test traffic master: write, read or write-then-read bursts at sequential or LFSR addresses, with read data checked against an LFSR pattern.
// Define MEM_TEST_MASTER_TIMEOUT_EN to compile in the stall watchdog that aborts the test.
module mem_test_master #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter int                BURST_W   = 4,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] DATA_TAPS = 32'h8000_0062,
    parameter logic [ADDR_W-1:0] ADDR_TAPS = 16'hB400,
    parameter int                TMO_W     = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               addr_rnd_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [CNT_W-1:0]   trans_cnt_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic [DATA_W-1:0]  seed_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [ADDR_W-1:0]  first_err_addr_o,
    output logic               timeout_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               write_o,
    output logic [DATA_W-1:0]  writedata_o,
    output logic               read_o,
    output logic [BURST_W-1:0] burstcount_o,
    input  logic               waitrequest_i,
    input  logic [DATA_W-1:0]  readdata_i,
    input  logic               readdatavalid_i
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_CMD, S_RD_DATA, S_DONE} state_t;

    state_t r_state, w_next;

    logic [1:0]         r_mode;
    logic               r_rnd;
    logic [ADDR_W-1:0]  r_addr0, r_addr, r_first_err;
    logic [CNT_W-1:0]   r_trans_cnt, r_trans, r_err_cnt;
    logic [BURST_W-1:0] r_blen, r_beat;
    logic [DATA_W-1:0]  r_seed, r_data;
    logic               r_done, r_timeout;

    logic               w_start, w_tmo_hit, w_wr_acc, w_rd_acc, w_rdv;
    logic               w_last_beat, w_last_trans, w_burst_end, w_reload;
    logic [1:0]         w_mode;
    logic [BURST_W-1:0] w_blen;
    logic [DATA_W-1:0]  w_seed;
    logic [ADDR_W-1:0]  w_addr0;

    function automatic logic [DATA_W-1:0] f_data_step(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], ^(v & DATA_TAPS)};
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr_step(input logic [ADDR_W-1:0] v);
        return {v[ADDR_W-2:0], ^(v & ADDR_TAPS)};
    endfunction

    // Config sanitising: reserved mode acts as write-only, zero seeds would lock the LFSRs.
    assign w_start = (r_state == S_IDLE) && start_i;
    assign w_mode  = (mode_i == 2'b11) ? 2'b00 : mode_i;
    assign w_blen  = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
    assign w_seed  = (seed_i == '0) ? '1 : seed_i;
    assign w_addr0 = (addr_rnd_i && (base_addr_i == '0)) ? '1 : base_addr_i;

    assign w_wr_acc     = (r_state == S_WR) && !waitrequest_i && !w_tmo_hit;
    assign w_rd_acc     = (r_state == S_RD_CMD) && !waitrequest_i && !w_tmo_hit;
    assign w_rdv        = (r_state == S_RD_DATA) && readdatavalid_i && !w_tmo_hit;
    assign w_last_beat  = (r_beat == r_blen - BURST_W'(1));
    assign w_last_trans = (r_trans == r_trans_cnt - CNT_W'(1));
    assign w_burst_end  = (w_wr_acc || w_rdv) && w_last_beat;
    assign w_reload     = w_burst_end && w_last_trans && (r_state == S_WR) && (r_mode == 2'b10);

`ifdef MEM_TEST_MASTER_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;

    assign w_tmo_hit = ((r_state == S_WR) || (r_state == S_RD_CMD) || (r_state == S_RD_DATA))
                       && (r_tmo == '1);

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state == S_IDLE) || (r_state == S_DONE)) begin
            r_tmo <= '0;
        end else if (((r_state == S_WR || r_state == S_RD_CMD) && !waitrequest_i) || readdatavalid_i) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end
`else
    assign w_tmo_hit = (TMO_W < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (trans_cnt_i == '0)     w_next = S_DONE;
                    else if (w_mode == 2'b01) w_next = S_RD_CMD;
                    else                       w_next = S_WR;
                end
            end
            S_WR: begin
                if (w_tmo_hit)                        w_next = S_DONE;
                else if (w_burst_end && w_last_trans) w_next = (r_mode == 2'b10) ? S_RD_CMD : S_DONE;
            end
            S_RD_CMD: begin
                if (w_tmo_hit)     w_next = S_DONE;
                else if (w_rd_acc) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (w_tmo_hit)        w_next = S_DONE;
                else if (w_burst_end) w_next = w_last_trans ? S_DONE : S_RD_CMD;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode      <= '0;
            r_rnd       <= 1'b0;
            r_addr0     <= '0;
            r_addr      <= '0;
            r_trans_cnt <= '0;
            r_trans     <= '0;
            r_blen      <= '0;
            r_beat      <= '0;
            r_seed      <= '0;
            r_data      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (w_tmo_hit) r_timeout <= 1'b1;
            if (w_start) begin
                r_mode      <= w_mode;
                r_rnd       <= addr_rnd_i;
                r_addr0     <= w_addr0;
                r_addr      <= w_addr0;
                r_trans_cnt <= trans_cnt_i;
                r_trans     <= '0;
                r_blen      <= w_blen;
                r_beat      <= '0;
                r_seed      <= w_seed;
                r_data      <= w_seed;
                r_err_cnt   <= '0;
                r_first_err <= '0;
                r_timeout   <= 1'b0;
            end
            if (w_wr_acc || w_rdv) begin
                r_data <= f_data_step(r_data);
                r_beat <= w_last_beat ? '0 : r_beat + BURST_W'(1);
            end
            if (w_burst_end) begin
                r_trans <= r_trans + CNT_W'(1);
                r_addr  <= r_rnd ? f_addr_step(r_addr) : r_addr + ADDR_W'(r_blen);
            end
            // Read phase replays exactly the pattern and addresses of the write phase.
            if (w_reload) begin
                r_data  <= r_seed;
                r_addr  <= r_addr0;
                r_trans <= '0;
            end
            if (w_rdv && (readdata_i != r_data)) begin
                if (r_err_cnt == '0) r_first_err <= r_addr;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign busy_o           = (r_state != S_IDLE) || r_done;
    assign done_o           = r_done;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_err;
    assign timeout_o        = r_timeout;
    assign address_o        = r_addr;
    assign write_o          = (r_state == S_WR) && !w_tmo_hit;
    assign writedata_o      = r_data;
    assign read_o           = (r_state == S_RD_CMD) && !w_tmo_hit;
    assign burstcount_o     = r_blen;

endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: table of test configurations run against a reference pattern model and a memory model, plus start/reset corner sequences.
`timescale 1ns/1ps
module tb_mem_test_master;

    logic        clk = 1'b0;
    logic        rst, start, addr_rnd, waitreq, rdv;
    logic [1:0]  mode;
    logic [15:0] base, tcnt;
    logic [3:0]  blen;
    logic [31:0] seed, rdata;
    logic        busy_o, done_o, timeout_o, write_o, read_o;
    logic [15:0] err_cnt_o, first_err_o, address_o;
    logic [31:0] writedata_o;
    logic [3:0]  burstcount_o;

    always #5 clk = ~clk;

    mem_test_master dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .addr_rnd_i(addr_rnd),
        .base_addr_i(base), .trans_cnt_i(tcnt), .burst_len_i(blen), .seed_i(seed),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_o),
        .timeout_o(timeout_o), .address_o(address_o), .write_o(write_o), .writedata_o(writedata_o),
        .read_o(read_o), .burstcount_o(burstcount_o), .waitrequest_i(waitreq),
        .readdata_i(rdata), .readdatavalid_i(rdv)
    );

    typedef struct {
        logic [1:0]  mode;
        bit          rnd;
        logic [15:0] base;
        logic [15:0] tc;
        logic [3:0]  bl;
        logic [31:0] seed;
        int          wait_pct;
        int          gap_pct;
        int          corrupt_burst;
        int          busy_start_at;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    logic [31:0] mem [logic [15:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference LFSR step: count tapped ones, parity becomes the new bit shifted in.
    function automatic logic [31:0] ref_data_step(input logic [31:0] v);
        int ones = 0;
        logic [31:0] taps = 32'h8000_0062;
        for (int i = 0; i < 32; i++) if (v[i] && taps[i]) ones++;
        return {v[30:0], 1'(ones % 2)};
    endfunction

    function automatic logic [15:0] ref_addr_step(input logic [15:0] v);
        int ones = 0;
        logic [15:0] taps = 16'hB400;
        for (int i = 0; i < 16; i++) if (v[i] && taps[i]) ones++;
        return {v[14:0], 1'(ones % 2)};
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int bl_eff, total, wi, ri, cyc, model_err, done_cyc, last_act;
        bit done_seen, prev_wstall, prev_rstall, real_rdv;
        logic [15:0] a, ma, model_first, p_addr;
        logic [31:0] d, val, p_data;
        logic [15:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] rsp[$];
        string t;
        t = $sformatf("v%0d", id);
        bl_eff = (v.bl == 0) ? 1 : int'(v.bl);
        total  = int'(v.tc) * bl_eff;
        a = (v.rnd && v.base == 0) ? 16'hFFFF : v.base;
        for (int k = 0; k < int'(v.tc); k++) begin
            exp_addr.push_back(a);
            a = v.rnd ? ref_addr_step(a) : a + 16'(bl_eff);
        end
        d = (v.seed == 0) ? 32'hFFFF_FFFF : v.seed;
        for (int k = 0; k < total; k++) begin
            exp_data.push_back(d);
            d = ref_data_step(d);
        end
        mem.delete();
        wi = 0; ri = 0; cyc = 0; model_err = 0; model_first = '0; done_cyc = 0; last_act = 0;
        done_seen = 0; prev_wstall = 0; prev_rstall = 0; p_addr = '0; p_data = '0;

        @(negedge clk);
        mode = v.mode; addr_rnd = v.rnd; base = v.base; tcnt = v.tc; blen = v.bl; seed = v.seed;
        start = 1'b1; waitreq = 1'b0; rdv = 1'b0;
        while (!done_seen && cyc < 4000) begin
            @(negedge clk);
            start    = (cyc == v.busy_start_at);
            mode     = 2'($urandom);
            addr_rnd = 1'($urandom);
            base     = 16'($urandom);
            tcnt     = 16'($urandom);
            blen     = 4'($urandom);
            seed     = $urandom;
            waitreq  = ($urandom_range(99) < v.wait_pct);
            real_rdv = 0;
            if (rsp.size() > 0) begin
                if ($urandom_range(99) >= v.gap_pct) begin
                    rdv = 1'b1; rdata = rsp.pop_front(); real_rdv = 1;
                end else begin
                    rdv = 1'b0; rdata = $urandom;
                end
            end else begin
                rdv = ($urandom_range(99) < 20); rdata = $urandom;
            end
            #1;
            if (cyc == 0) begin
                check({t, "_busy_after_start"}, busy_o, 1);
                check({t, "_first_cmd"}, write_o | read_o, 1);
            end
            if (write_o) begin
                if (prev_wstall) begin
                    check({t, "_wr_addr_stable"}, address_o, p_addr);
                    check({t, "_wr_data_stable"}, writedata_o, p_data);
                end
                if (!waitreq) begin
                    if (wi < total) begin
                        check({t, "_wr_addr"}, address_o, exp_addr[wi / bl_eff]);
                        check({t, "_wr_data"}, writedata_o, exp_data[wi]);
                    end
                    check({t, "_wr_burstcount"}, burstcount_o, bl_eff);
                    ma = address_o + 16'(wi % bl_eff);
                    mem[ma] = writedata_o;
                    wi++; last_act = cyc; prev_wstall = 0;
                end else begin
                    prev_wstall = 1; p_addr = address_o; p_data = writedata_o;
                end
            end else prev_wstall = 0;
            if (read_o) begin
                if (prev_rstall) check({t, "_rd_addr_stable"}, address_o, p_addr);
                if (!waitreq) begin
                    if (ri < int'(v.tc)) check({t, "_rd_addr"}, address_o, exp_addr[ri]);
                    check({t, "_rd_burstcount"}, burstcount_o, bl_eff);
                    for (int j = 0; j < bl_eff; j++) begin
                        ma  = address_o + 16'(j);
                        val = mem.exists(ma) ? mem[ma] : {16'h5A5A, ma};
                        if (ri == v.corrupt_burst && j == 3) val = val ^ 32'h0000_0100;
                        if (ri * bl_eff + j < total && val != exp_data[ri * bl_eff + j]) begin
                            if (model_err == 0) model_first = exp_addr[ri];
                            model_err++;
                        end
                        rsp.push_back(val);
                    end
                    ri++; prev_rstall = 0;
                end else begin
                    prev_rstall = 1; p_addr = address_o;
                end
            end else prev_rstall = 0;
            if (real_rdv) last_act = cyc;
            if (done_o) begin done_seen = 1; done_cyc = cyc; end
            cyc++;
        end
        check({t, "_done_seen"}, done_seen, 1);
        check({t, "_done_latency"}, done_cyc - last_act, 2);
        @(negedge clk);
        start = 1'b0; rdv = 1'b0; waitreq = 1'b0;
        #1;
        check({t, "_done_one_cycle"}, done_o, 0);
        check({t, "_idle_after_done"}, busy_o, 0);
        check({t, "_wr_beats"}, wi, v.exp_wr);
        check({t, "_rd_cmds"}, ri, v.exp_rd);
        check({t, "_rsp_drained"}, rsp.size(), 0);
        check({t, "_err_cnt"}, err_cnt_o, model_err);
        check({t, "_first_err"}, first_err_o, model_err != 0 ? model_first : 16'h0);
        check({t, "_timeout"}, timeout_o, 0);
    endtask

    vec_t tbl[8];
    int   done_pulses;

    initial begin
        tbl[0] = '{2'b00, 1'b0, 16'h0010, 16'd2,  4'd4,  32'h0000_0001, 0,  0,  -1, -1, 8,   0};
        tbl[1] = '{2'b10, 1'b1, 16'hACE1, 16'd16, 4'd8,  32'hDEAD_BEEF, 0,  0,  -1, -1, 128, 16};
        tbl[2] = '{2'b10, 1'b1, 16'hACE1, 16'd16, 4'd8,  32'hDEAD_BEEF, 0,  0,  5,  -1, 128, 16};
        tbl[3] = '{2'b10, 1'b1, 16'hACE1, 16'd16, 4'd8,  32'hDEAD_BEEF, 50, 30, -1, 7,  128, 16};
        tbl[4] = '{2'b10, 1'b0, 16'hFFF0, 16'd5,  4'd0,  32'h0000_0000, 0,  0,  -1, -1, 5,   5};
        tbl[5] = '{2'b01, 1'b0, 16'h0100, 16'd3,  4'd2,  32'h0000_0007, 0,  0,  -1, -1, 0,   3};
        tbl[6] = '{2'b11, 1'b1, 16'h0000, 16'd4,  4'd15, 32'h1234_5678, 20, 0,  -1, -1, 60,  0};
        tbl[7] = '{2'b10, 1'b0, 16'hFFFC, 16'd3,  4'd3,  32'h0000_0001, 30, 50, -1, -1, 9,   3};

        rst = 1'b1; start = 1'b0; mode = '0; addr_rnd = 1'b0; base = '0; tcnt = '0;
        blen = '0; seed = '0; waitreq = 1'b0; rdv = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {busy_o, done_o, timeout_o, write_o, read_o, burstcount_o}, 0);
        check("reset_data", {err_cnt_o, first_err_o, address_o, writedata_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // trans_cnt = 0: no bus activity, done two cycles after the start pulse.
        @(negedge clk);
        mode = 2'b10; tcnt = 16'd0; blen = 4'd4; seed = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; #1;
        check("tc0_busy", busy_o, 1);
        check("tc0_no_done_yet", done_o, 0);
        check("tc0_no_bus_c1", write_o | read_o, 0);
        @(negedge clk); #1;
        check("tc0_done", done_o, 1);
        check("tc0_no_bus_c2", write_o | read_o, 0);
        @(negedge clk); #1;
        check("tc0_done_cleared", done_o, 0);
        check("tc0_idle", busy_o, 0);

        // Reset in the middle of a burst.
        @(negedge clk);
        mode = 2'b00; addr_rnd = 1'b0; base = 16'h0040; tcnt = 16'd4; blen = 4'd4;
        seed = 32'd9; waitreq = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_writing", write_o, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        check("rst_mid_ctrl", {busy_o, done_o, timeout_o, write_o, read_o, burstcount_o}, 0);
        check("rst_mid_data", {err_cnt_o, first_err_o, address_o, writedata_o}, 0);
        rst = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (done_o || busy_o) done_pulses++;
        end
        check("rst_mid_no_done", done_pulses, 0);

        run_vec(8, tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
